// File: rtl/fp_div_if.sv
// ---------------------------------------------------------------------------
// fp_div_if
// Request/result bundle for the binary32 divider.
//   start     request strobe (master -> slave)
//   dividend  binary32 numerator (master -> slave)
//   divisor   binary32 denominator (master -> slave)
//   quotient  binary32 result, held until the next completion (slave -> master)
//   done      one-cycle completion pulse (slave -> master)
//   busy      division in flight (slave -> master)
// ---------------------------------------------------------------------------
interface fp_div_if;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] quotient;
   logic        done;
   logic        busy;

   modport master (output start, dividend, divisor, input quotient, done, busy);
   modport slave  (input start, dividend, divisor, output quotient, done, busy);
endinterface

// File: rtl/fp_div.sv
// ---------------------------------------------------------------------------
// fp_div
// IEEE-754 binary32 divider, round-to-nearest-even, radix-2 restoring divide
// producing one quotient bit per clock. Fixed latency of 27 cycles from the
// accepting edge to the done pulse, specials included. Subnormal inputs are
// read as zero and subnormal results flush to signed zero.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any division in flight
//   bus    fp_div_if.slave: start/dividend/divisor in, quotient/done/busy out
// ---------------------------------------------------------------------------
module fp_div (
   input  logic     clk,
   input  logic     reset,
   fp_div_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIV   = 2'd1,
      S_ROUND = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [4:0]         cnt_r;
   logic [24:0]        rem_r;
   logic [23:0]        mb_r;
   logic [25:0]        q_r;
   logic signed [9:0]  exp_r;
   logic               sign_r;
   logic               special_r;
   logic [31:0]        special_val_r;
   logic [31:0]        quotient_r;
   logic               done_r;
   logic               busy_r;

   logic               accept_s;
   logic [7:0]         ea_s;
   logic [7:0]         eb_s;
   logic [22:0]        fa_s;
   logic [22:0]        fb_s;
   logic               sign_s;
   logic               spec_s;
   logic [31:0]        spec_val_s;
   logic signed [9:0]  exp_init_s;
   logic               qbit_s;
   logic [23:0]        rem_sub_s;
   logic [23:0]        mant_s;
   logic               guard_s;
   logic               sticky_s;
   logic signed [9:0]  exp_norm_s;
   logic               round_up_s;
   logic [24:0]        mant_rnd_s;
   logic signed [9:0]  exp_fin_s;
   logic [22:0]        frac_s;
   logic [31:0]        result_s;

   assign accept_s = (state_r == S_IDLE) && bus.start;
   assign ea_s     = bus.dividend[30:23];
   assign eb_s     = bus.divisor[30:23];
   assign fa_s     = bus.dividend[22:0];
   assign fb_s     = bus.divisor[22:0];
   assign sign_s   = bus.dividend[31] ^ bus.divisor[31];

   // 10-bit signed intermediate so that underflow/overflow stay visible
   assign exp_init_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + 10'sd127;

   assign bus.quotient = quotient_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;

   // Operand classification: special results are decided at accept time
   always_comb begin
      logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      a_nan  = (ea_s == 8'hFF) && (fa_s != 23'd0);
      b_nan  = (eb_s == 8'hFF) && (fb_s != 23'd0);
      a_inf  = (ea_s == 8'hFF) && (fa_s == 23'd0);
      b_inf  = (eb_s == 8'hFF) && (fb_s == 23'd0);
      a_zero = (ea_s == 8'h00);    // subnormals read as zero
      b_zero = (eb_s == 8'h00);
      spec_s     = 1'b1;
      spec_val_s = 32'h7FC0_0000;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_val_s = 32'h7FC0_0000;
      end else if (a_inf || b_zero) begin
         spec_val_s = {sign_s, 8'hFF, 23'd0};
      end else if (a_zero || b_inf) begin
         spec_val_s = {sign_s, 31'd0};
      end else begin
         spec_s     = 1'b0;
         spec_val_s = 32'd0;
      end
   end

   // One restoring-divide step: subtract the divisor when it fits
   always_comb begin
      qbit_s = (rem_r >= {1'b0, mb_r});
      if (qbit_s) begin
         rem_sub_s = 24'(rem_r - {1'b0, mb_r});
      end else begin
         rem_sub_s = rem_r[23:0];
      end
   end

   // Normalize, round to nearest even and pack the final result
   always_comb begin
      // q_r holds floor(ma/mb * 2^25); bit 25 set means the ratio is >= 1
      if (q_r[25]) begin
         mant_s     = q_r[25:2];
         guard_s    = q_r[1];
         sticky_s   = q_r[0] | (rem_r != 25'd0);
         exp_norm_s = exp_r;
      end else begin
         mant_s     = q_r[24:1];
         guard_s    = q_r[0];
         sticky_s   = (rem_r != 25'd0);
         exp_norm_s = exp_r - 10'sd1;
      end
      round_up_s = guard_s & (sticky_s | mant_s[0]);
      mant_rnd_s = {1'b0, mant_s} + {24'd0, round_up_s};
      if (mant_rnd_s[24]) begin
         exp_fin_s = exp_norm_s + 10'sd1;
         frac_s    = mant_rnd_s[23:1];
      end else begin
         exp_fin_s = exp_norm_s;
         frac_s    = mant_rnd_s[22:0];
      end
      if (special_r) begin
         result_s = special_val_r;
      end else if (exp_fin_s <= 10'sd0) begin
         result_s = {sign_r, 31'd0};
      end else if (exp_fin_s >= 10'sd255) begin
         result_s = {sign_r, 8'hFF, 23'd0};
      end else begin
         result_s = {sign_r, exp_fin_s[7:0], frac_s};
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: 26 divide cycles then one rounding cycle
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt_s = S_DIV;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_DIV: begin
            if (cnt_r == 5'd25) begin
               state_nxt_s = S_ROUND;
            end else begin
               state_nxt_s = S_DIV;
            end
         end
         S_ROUND: state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Datapath: operand capture on accept, then one quotient bit per cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r         <= 5'd0;
         rem_r         <= 25'd0;
         mb_r          <= 24'd0;
         q_r           <= 26'd0;
         exp_r         <= 10'sd0;
         sign_r        <= 1'b0;
         special_r     <= 1'b0;
         special_val_r <= 32'd0;
      end else if (accept_s) begin
         cnt_r         <= 5'd0;
         rem_r         <= {2'b01, fa_s};
         mb_r          <= {1'b1, fb_s};
         q_r           <= 26'd0;
         exp_r         <= exp_init_s;
         sign_r        <= sign_s;
         special_r     <= spec_s;
         special_val_r <= spec_val_s;
      end else if (state_r == S_DIV) begin
         cnt_r <= cnt_r + 5'd1;
         rem_r <= {rem_sub_s, 1'b0};
         q_r   <= {q_r[24:0], qbit_s};
      end
   end

   // Registered outputs: result written and done pulsed on the rounding edge
   always_ff @(posedge clk) begin
      if (reset) begin
         quotient_r <= 32'd0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         done_r <= (state_r == S_ROUND);
         if (state_r == S_ROUND) begin
            quotient_r <= result_s;
            busy_r     <= 1'b0;
         end else if (accept_s) begin
            busy_r     <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fp_div.sv
// ---------------------------------------------------------------------------
// tb_fp_div
// Self-checking bench for fp_div: directed vectors, randomized operands
// against an integer-arithmetic reference model, handshake and reset cases.
// ---------------------------------------------------------------------------
module tb_fp_div;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fp_div_if bus ();

   fp_div u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference: exact ratio by long integer division, then RNE/DAZ/FTZ rules
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic              sign;
      logic [7:0]        ea, eb;
      logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      longint unsigned   num, quo, rm, mant;
      logic              g, st;
      int                e;
      sign   = a[31] ^ b[31];
      ea     = a[30:23];
      eb     = b[30:23];
      a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC0_0000;
      if (a_inf || b_zero) return {sign, 8'hFF, 23'd0};
      if (a_zero || b_inf) return {sign, 31'd0};
      num = longint'({1'b1, a[22:0]}) << 40;
      quo = num / longint'({1'b1, b[22:0]});
      rm  = num % longint'({1'b1, b[22:0]});
      e   = int'(ea) - int'(eb) + 127;
      if (quo >= (64'd1 << 40)) begin
         mant = quo >> 17;
         g    = quo[16];
         st   = (quo[15:0] != 16'd0) || (rm != 0);
      end else begin
         mant = quo >> 16;
         g    = quo[15];
         st   = (quo[14:0] != 15'd0) || (rm != 0);
         e    = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
         mant = 64'd1 << 23;
         e    = e + 1;
      end
      if (e <= 0) return {sign, 31'd0};
      if (e >= 255) return {sign, 8'hFF, 23'd0};
      return {sign, e[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_operand();
      int unsigned mode;
      logic [31:0] v;
      mode = $urandom_range(0, 11);
      v    = $urandom;
      case (mode)
         0:       v = {v[31], 31'd0};
         1:       v = {v[31], 8'hFF, 23'd0};
         2:       v = {v[31], 8'hFF, v[22:1], 1'b1};
         3:       v = {v[31], 8'h00, v[22:0]};
         4:       v = v;
         default: v = {v[31], 8'($urandom_range(64, 190)), v[22:0]};
      endcase
      return v;
   endfunction

   // Issue one division and wait (bounded) for done; lat counts edges after accept
   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat,
                        output logic busy_acc, output logic busy_done);
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk); #1;
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      busy_acc     = bus.busy;
      lat          = 0;
      while (!bus.done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res       = bus.quotient;
      busy_done = bus.busy;
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = 32'd0;
      bus.divisor  = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient: got %h expected %h", bus.quotient, 32'd0); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] va [8] = '{32'h3FF33398, 32'h3F800000, 32'hC0C00000, 32'h3F800000,
                              32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 32'h00800000};
      logic [31:0] vb [8] = '{32'h3F816990, 32'h40400000, 32'h40000000, 32'h40000000,
                              32'h00000000, 32'h00000000, 32'h3E800000, 32'h4B000000};
      logic [31:0] ve [8] = '{32'h3FF08C1E, 32'h3EAAAAAB, 32'hC0400000, 32'h3F000000,
                              32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000};
      logic [31:0] res;
      int          lat;
      logic        ba, bd;
      for (int i = 0; i < 8; i++) begin
         issue(va[i], vb[i], res, lat, ba, bd);
         checks++; if (res !== ve[i]) begin errors++; $display("FAIL directed_%0d_value: %h / %h got %h expected %h", i, va[i], vb[i], res, ve[i]); end
         checks++; if (lat != 27) begin errors++; $display("FAIL directed_%0d_latency: got %0d expected 27", i, lat); end
         checks++; if (ba !== 1'b1) begin errors++; $display("FAIL directed_%0d_busy_accept: got %b expected 1", i, ba); end
         checks++; if (bd !== 1'b0) begin errors++; $display("FAIL directed_%0d_busy_done: got %b expected 0", i, bd); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res, exp_v;
      int          lat;
      logic        ba, bd;
      for (int i = 0; i < 300; i++) begin
         a     = rand_operand();
         b     = rand_operand();
         exp_v = ref_div(a, b);
         issue(a, b, res, lat, ba, bd);
         checks++; if (res !== exp_v) begin errors++; $display("FAIL random_value: %h / %h got %h expected %h", a, b, res, exp_v); end
         checks++; if (lat != 27) begin errors++; $display("FAIL random_latency: %h / %h got %0d expected 27", a, b, lat); end
      end
   endtask

   task automatic test_busy_ignore();
      int lat, extra_done, busy_seen;
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.dividend = 32'hC0C00000;
      bus.divisor  = 32'h40000000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat       = 0;
      while (!bus.done && lat < 40) begin
         if (lat == 5) begin
            bus.start = 1'b1; bus.dividend = 32'h3F800000; bus.divisor = 32'h40400000;
         end else if (lat == 26) begin
            bus.start = 1'b1; bus.dividend = 32'h3F800000; bus.divisor = 32'h40000000;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus.start = 1'b0;
      checks++; if (lat != 27) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 27", lat); end
      checks++; if (bus.quotient !== 32'hC0400000) begin errors++; $display("FAIL busy_ignore_value: got %h expected %h", bus.quotient, 32'hC0400000); end
      extra_done = 0;
      busy_seen  = 0;
      repeat (35) begin
         @(posedge clk); #1;
         if (bus.done) extra_done++;
         if (bus.busy) busy_seen++;
      end
      checks++; if (extra_done != 0) begin errors++; $display("FAIL busy_ignore_extra_done: got %0d expected 0", extra_done); end
      checks++; if (busy_seen != 0) begin errors++; $display("FAIL busy_ignore_busy: got %0d busy cycles expected 0", busy_seen); end
   endtask

   task automatic test_reset_mid();
      int          extra_done;
      logic [31:0] res;
      int          lat;
      logic        ba, bd;
      checks++; if (bus.quotient === 32'd0) begin errors++; $display("FAIL reset_mid_precond: got %h expected nonzero", bus.quotient); end
      @(posedge clk); #1;
      bus.start    = 1'b1;
      bus.dividend = 32'h3F800000;
      bus.divisor  = 32'h40400000;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_mid_quotient: got %h expected %h", bus.quotient, 32'd0); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_mid_done: got %b expected 0", bus.done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", bus.busy); end
      extra_done = 0;
      repeat (35) begin
         @(posedge clk); #1;
         if (bus.done) extra_done++;
      end
      checks++; if (extra_done != 0) begin errors++; $display("FAIL reset_mid_late_done: got %0d expected 0", extra_done); end
      issue(32'h3F800000, 32'h40000000, res, lat, ba, bd);
      checks++; if (res !== 32'h3F000000) begin errors++; $display("FAIL reset_mid_recover: got %h expected %h", res, 32'h3F000000); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] res1, res2;
      int          lat1, lat2;
      logic        ba, bd;
      issue(32'h40490FDB, 32'h402DF854, res1, lat1, ba, bd);
      checks++; if (res1 !== ref_div(32'h40490FDB, 32'h402DF854)) begin errors++; $display("FAIL b2b_first: got %h expected %h", res1, ref_div(32'h40490FDB, 32'h402DF854)); end
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse_width: got %b expected 0", bus.done); end
      checks++; if (bus.quotient !== res1) begin errors++; $display("FAIL b2b_hold: got %h expected %h", bus.quotient, res1); end
      issue(32'hC2F6E979, 32'hBF9D70A4, res2, lat2, ba, bd);
      checks++; if (res2 !== ref_div(32'hC2F6E979, 32'hBF9D70A4)) begin errors++; $display("FAIL b2b_second: got %h expected %h", res2, ref_div(32'hC2F6E979, 32'hBF9D70A4)); end
      checks++; if (lat2 != 27) begin errors++; $display("FAIL b2b_latency: got %0d expected 27", lat2); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
